// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator
// Passive end of a 4x4 row/column keypad scan. When a key is commanded it
// plays a press: closing bounce, solid hold, opening bounce, then an open gap.
// While the contact is closed it pulls the matching column low whenever the
// scanner strobes the latched row.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no key pressed, waiting for press_req
// BOUNCE_IN  | press bounce: closed P, open P, repeated T times
// HELD       | contact solidly closed for the hold time
// BOUNCE_OUT | release bounce: open P, closed P, repeated T times
// GAP        | contact open for the gap time before done
module keypad_matrix_emulator #(
  parameter int unsigned BOUNCE_PERIOD  = 2,
  parameter int unsigned BOUNCE_TOGGLES = 2,
  parameter int unsigned HOLD_CYCLES    = 10,
  parameter int unsigned GAP_CYCLES     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       press_req,
  output logic       busy,
  output logic       done,
  input  logic [3:0] rows,
  output logic [3:0] cols
);

  // Phase lengths with zero-clamping applied once, so every comparison
  // below sees the effective value.
  localparam logic [31:0] P_LEN  = (BOUNCE_PERIOD == 0) ? 32'd1 : 32'(BOUNCE_PERIOD);
  localparam logic [31:0] T_NUM  = 32'(BOUNCE_TOGGLES);
  localparam logic [31:0] H_LEN  = (HOLD_CYCLES == 0) ? 32'd1 : 32'(HOLD_CYCLES);
  localparam logic [31:0] G_LEN  = 32'(GAP_CYCLES);

  // Down-counters load "length - 1" and the phase ends when they reach 0.
  localparam logic [31:0] P_LAST = P_LEN - 32'd1;
  localparam logic [31:0] H_LAST = H_LEN - 32'd1;
  localparam logic [31:0] G_LAST = (G_LEN == 32'd0) ? 32'd0 : G_LEN - 32'd1;
  localparam logic [31:0] T_LAST = (T_NUM == 32'd0) ? 32'd0 : T_NUM - 32'd1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    HELD       = 3'd2,
    BOUNCE_OUT = 3'd3,
    GAP        = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [31:0] toggles, toggles_nxt;
  logic        half, half_nxt;
  logic [3:0]  key, key_nxt;
  logic        contact;
  logic [3:0]  cols_nxt;

  // State, phase counters and latched key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 32'd0;
      toggles <= 32'd0;
      half    <= 1'b0;
      key     <= 4'h0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      toggles <= toggles_nxt;
      half    <= half_nxt;
      key     <= key_nxt;
    end
  end

  // Next-state logic; "half" selects the first or second half of a bounce pair.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    toggles_nxt = toggles;
    half_nxt    = half;
    key_nxt     = key;
    case (state)
      IDLE: begin
        if (press_req) begin
          key_nxt  = key_code;
          half_nxt = 1'b0;
          if (T_NUM != 32'd0) begin
            state_nxt   = BOUNCE_IN;
            cnt_nxt     = P_LAST;
            toggles_nxt = T_LAST;
          end else begin
            state_nxt = HELD;
            cnt_nxt   = H_LAST;
          end
        end
      end
      BOUNCE_IN: begin
        if (cnt != 32'd0) begin
          cnt_nxt = cnt - 32'd1;
        end else if (!half) begin
          half_nxt = 1'b1;
          cnt_nxt  = P_LAST;
        end else if (toggles != 32'd0) begin
          toggles_nxt = toggles - 32'd1;
          half_nxt    = 1'b0;
          cnt_nxt     = P_LAST;
        end else begin
          state_nxt = HELD;
          half_nxt  = 1'b0;
          cnt_nxt   = H_LAST;
        end
      end
      HELD: begin
        if (cnt != 32'd0) begin
          cnt_nxt = cnt - 32'd1;
        end else if (T_NUM != 32'd0) begin
          state_nxt   = BOUNCE_OUT;
          half_nxt    = 1'b0;
          cnt_nxt     = P_LAST;
          toggles_nxt = T_LAST;
        end else if (G_LEN != 32'd0) begin
          state_nxt = GAP;
          cnt_nxt   = G_LAST;
        end else begin
          state_nxt = IDLE;
        end
      end
      BOUNCE_OUT: begin
        if (cnt != 32'd0) begin
          cnt_nxt = cnt - 32'd1;
        end else if (!half) begin
          half_nxt = 1'b1;
          cnt_nxt  = P_LAST;
        end else if (toggles != 32'd0) begin
          toggles_nxt = toggles - 32'd1;
          half_nxt    = 1'b0;
          cnt_nxt     = P_LAST;
        end else if (G_LEN != 32'd0) begin
          state_nxt = GAP;
          half_nxt  = 1'b0;
          cnt_nxt   = G_LAST;
        end else begin
          state_nxt = IDLE;
          half_nxt  = 1'b0;
        end
      end
      GAP: begin
        if (cnt != 32'd0) begin
          cnt_nxt = cnt - 32'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Contact closes in the first half of a press-bounce pair and in the
  // second half of a release-bounce pair, and throughout the hold.
  always_comb begin
    contact = ((state == BOUNCE_IN) && !half) ||
              (state == HELD) ||
              ((state == BOUNCE_OUT) && half);
  end

  // Column pattern seen by the scanner for the current contact and row strobe.
  always_comb begin
    cols_nxt = 4'hF;
    if (contact && !rows[key[3:2]]) begin
      cols_nxt[key[1:0]] = 1'b0;
    end
  end

  assign busy = (state != IDLE);

  // Registered column drive and completion pulse; reset cuts any pending done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols <= 4'hF;
      done <= 1'b0;
    end else begin
      cols <= cols_nxt;
      done <= (state != IDLE) && (state_nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Bench for keypad_matrix_emulator: a per-cycle scoreboard against a
// schedule-based model, table-driven presses, and hand-written corner cases.
module tb_keypad_matrix_emulator;

  localparam int P = 2;
  localparam int T = 2;
  localparam int H = 10;
  localparam int G = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_code;
  logic       press_req;
  logic       busy;
  logic       done;
  logic [3:0] rows;
  logic [3:0] cols;

  logic [3:0] nb_key;
  logic       nb_req;
  logic       nb_busy;
  logic       nb_done;
  logic [3:0] nb_rows;
  logic [3:0] nb_cols;

  int n_tests = 0;
  int n_fail  = 0;

  keypad_matrix_emulator dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .press_req(press_req),
    .busy(busy), .done(done), .rows(rows), .cols(cols)
  );

  keypad_matrix_emulator #(
    .BOUNCE_PERIOD(2), .BOUNCE_TOGGLES(0), .HOLD_CYCLES(3), .GAP_CYCLES(0)
  ) dut_nb (
    .clk(clk), .rst_n(rst_n), .key_code(nb_key), .press_req(nb_req),
    .busy(nb_busy), .done(nb_done), .rows(nb_rows), .cols(nb_cols)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: per-cycle contact schedule ----------------
  bit         m_sched[$];
  int         m_pos;
  logic [3:0] m_key;
  logic [3:0] m_cols;
  logic       m_done;

  function automatic void build_sched();
    m_sched.delete();
    for (int t = 0; t < T; t++) begin
      repeat (P) m_sched.push_back(1'b1);
      repeat (P) m_sched.push_back(1'b0);
    end
    repeat (H) m_sched.push_back(1'b1);
    for (int t = 0; t < T; t++) begin
      repeat (P) m_sched.push_back(1'b0);
      repeat (P) m_sched.push_back(1'b1);
    end
    repeat (G) m_sched.push_back(1'b0);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit c;
    if (!rst_n) begin
      m_sched.delete();
      m_pos  = 0;
      m_key  = 4'h0;
      m_cols = 4'hF;
      m_done = 1'b0;
    end else begin
      c = (m_pos < m_sched.size()) ? m_sched[m_pos] : 1'b0;
      m_cols = (c && rows[m_key[3:2]] == 1'b0) ? ~(4'b0001 << m_key[1:0]) : 4'hF;
      m_done = 1'b0;
      if (m_pos < m_sched.size()) begin
        m_pos++;
        if (m_pos == m_sched.size()) m_done = 1'b1;
      end else if (press_req) begin
        build_sched();
        m_pos = 0;
        m_key = key_code;
      end
    end
  end

  // Scoreboard on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    check("sb_busy", {31'd0, busy}, {31'd0, (m_pos < m_sched.size())});
    check("sb_done", {31'd0, done}, {31'd0, m_done});
    check("sb_cols", {28'd0, cols}, {28'd0, m_cols});
  end

  // ---------------- helpers ----------------
  task automatic wait_done(input string name, output int busy_n);
    bit got;
    got = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (busy) busy_n++;
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    check({name, "_done_seen"}, {31'd0, got}, 32'd1);
  endtask

  typedef struct {
    logic [3:0] key;
    logic [3:0] rws;
    logic [3:0] closed_cols;
    int         low_cycles;
    int         busy_cycles;
  } vec_t;

  vec_t       vecs[6];
  logic [3:0] seg_v[10] = '{4'b1011, 4'hF, 4'b1011, 4'hF, 4'b1011,
                            4'hF, 4'b1011, 4'hF, 4'b1011, 4'hF};
  int         seg_n[10] = '{2, 2, 2, 2, 10, 2, 2, 2, 2, 4};
  logic [3:0] exp_seq[$];

  initial begin
    int bn, low_n, bad, seen;
    logic [3:0] prev_rows;

    rst_n = 1'b0; key_code = 4'h0; press_req = 1'b0; rows = 4'hF;
    nb_key = 4'h0; nb_req = 1'b0; nb_rows = 4'hF;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_cols", {28'd0, cols}, 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Exact column sequence for key 6 on row 1 with default timing.
    foreach (seg_v[s]) repeat (seg_n[s]) exp_seq.push_back(seg_v[s]);
    key_code = 4'h6; rows = 4'b1101; press_req = 1'b1;
    @(negedge clk);
    press_req = 1'b0;
    check("basic_busy_rise", {31'd0, busy}, 32'd1);
    check("basic_cols_first", {28'd0, cols}, 32'hF);
    bn = 1; bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy) bn++;
      if (cols !== exp_seq[k]) begin
        bad++;
        $display("FAIL basic_seq[%0d] actual=%b required=%b", k, cols, exp_seq[k]);
      end
    end
    check("basic_seq_errors", bad, 0);
    check("basic_busy_len", bn, 30);
    check("basic_done_31", {31'd0, done}, 32'd1);
    check("basic_busy_fall", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("basic_done_single", {31'd0, done}, 32'd0);

    // Table-driven presses, each started in the done cycle of the previous.
    vecs[0] = '{4'h6, 4'b1101, 4'b1011, 18, 30};
    vecs[1] = '{4'h6, 4'b1110, 4'b1111,  0, 30};
    vecs[2] = '{4'hF, 4'b0111, 4'b0111, 18, 30};
    vecs[3] = '{4'h0, 4'b1110, 4'b1110, 18, 30};
    vecs[4] = '{4'h9, 4'b1011, 4'b1101, 18, 30};
    vecs[5] = '{4'h9, 4'b0000, 4'b1101, 18, 30};
    foreach (vecs[v]) begin
      key_code = vecs[v].key; rows = vecs[v].rws; press_req = 1'b1;
      @(negedge clk);
      press_req = 1'b0;
      bn = 0; low_n = 0; bad = 0; seen = 0;
      for (int i = 0; i < 100 && seen == 0; i++) begin
        if (busy) bn++;
        if (cols !== 4'hF) begin
          low_n++;
          if (cols !== vecs[v].closed_cols) bad++;
        end
        if (done) seen = 1;
        else @(negedge clk);
      end
      check($sformatf("vec%0d_done_seen", v), seen, 1);
      check($sformatf("vec%0d_busy_len", v), bn, vecs[v].busy_cycles);
      check($sformatf("vec%0d_low_cycles", v), low_n, vecs[v].low_cycles);
      check($sformatf("vec%0d_bad_cols", v), bad, 0);
    end
    @(negedge clk);

    // Collision: mid-sequence request with another key is ignored,
    // a request in the done cycle is accepted on the next edge.
    key_code = 4'h6; rows = 4'b1101; press_req = 1'b1;
    @(negedge clk);
    press_req = 1'b0;
    repeat (10) @(negedge clk);
    key_code = 4'h0; press_req = 1'b1;
    @(negedge clk);
    press_req = 1'b0;
    check("collide_cols_keeps_key", {28'd0, cols}, 32'b1011);
    wait_done("collide", bn);
    check("collide_busy_remaining", bn, 19);
    key_code = 4'h3; rows = 4'b1110; press_req = 1'b1;
    @(negedge clk);
    press_req = 1'b0;
    check("done_cycle_req_accepted", {31'd0, busy}, 32'd1);
    wait_done("after_done_req", bn);
    check("after_done_req_busy", bn, 30);
    @(negedge clk);

    // Scanning loop: rotating one-hot-low rows with key 9 held.
    key_code = 4'h9; rows = 4'b1110; press_req = 1'b1;
    @(negedge clk);
    press_req = 1'b0;
    bad = 0; low_n = 0; seen = 0; prev_rows = rows;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      if (cols[1] == 1'b0) begin
        low_n++;
        if (prev_rows !== 4'b1011) bad++;
      end
      if (cols[0] == 1'b0 || cols[2] == 1'b0 || cols[3] == 1'b0) bad++;
      if (done) seen = 1;
      prev_rows = rows;
      if (i % 4 == 3) rows = {rows[2:0], rows[3]};
      if (seen == 0) @(negedge clk);
    end
    check("scan_done_seen", seen, 1);
    check("scan_wrong_col", bad, 0);
    check("scan_saw_key", {31'd0, (low_n > 0)}, 32'd1);
    @(negedge clk);

    // No-bounce instance: T=0, H=3, G=0.
    nb_key = 4'hF; nb_rows = 4'b0111; nb_req = 1'b1;
    @(negedge clk);
    nb_req = 1'b0;
    check("nb_busy_c1", {31'd0, nb_busy}, 32'd1);
    check("nb_cols_c1", {28'd0, nb_cols}, 32'hF);
    @(negedge clk);
    check("nb_busy_c2", {31'd0, nb_busy}, 32'd1);
    check("nb_cols_c2", {28'd0, nb_cols}, 32'b0111);
    @(negedge clk);
    check("nb_busy_c3", {31'd0, nb_busy}, 32'd1);
    check("nb_cols_c3", {28'd0, nb_cols}, 32'b0111);
    @(negedge clk);
    check("nb_busy_c4", {31'd0, nb_busy}, 32'd0);
    check("nb_done_c4", {31'd0, nb_done}, 32'd1);
    check("nb_cols_c4", {28'd0, nb_cols}, 32'b0111);
    @(negedge clk);
    check("nb_done_c5", {31'd0, nb_done}, 32'd0);
    check("nb_cols_c5", {28'd0, nb_cols}, 32'hF);

    // Reset mid-HELD with the row strobed.
    key_code = 4'h6; rows = 4'b1101; press_req = 1'b1;
    @(negedge clk);
    press_req = 1'b0;
    repeat (11) @(negedge clk);
    check("rst_pre_cols", {28'd0, cols}, 32'b1011);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_cols", {28'd0, cols}, 32'hF);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("rst_no_done", seen, 0);

    // Randomized traffic, checked by the scoreboard every cycle.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 7) rows = ~(4'b0001 << $urandom_range(0, 3));
      else rows = 4'($urandom);
      key_code = 4'($urandom);
      press_req = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    press_req = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
